// File: rtl/rv32i_lsu.sv
// rv32i_lsu: single-outstanding RV32I load/store unit.
// It issues a byte-enabled memory handshake that tolerates wait states.
// Optional feature macro: LSU_TIMEOUT_EN. When it is defined, the LSU
// abandons the BUS state after TIMEOUT_CYC cycles with no mem_ack.
module rv32i_lsu #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t      state, state_nx;
    logic        we_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic        size_bad, misal, range_bad;
    logic [1:0]  chk_err;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic        timed_out;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) < 4) ? 4 : $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt;

    // Count elapsed BUS cycles; held at zero outside BUS so it restarts on entry
    always_ff @(posedge clk) begin
        if (rst || state != S_BUS) to_cnt <= '0;
        else                       to_cnt <= to_cnt + 1'b1;
    end

    // A mem_ack in the final allowed cycle takes precedence over the timeout
    assign timed_out = (state == S_BUS) && !mem_ack && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYC;
    assign timed_out  = 1'b0;
`endif

    // Decode the request: legality checks, byte enables and lane-replicated write data
    always_comb begin
        size_bad  = req_we ? (req_size[2] || (req_size[1:0] == 2'b11))
                           : (req_size == 3'b011 || req_size == 3'b110 || req_size == 3'b111);
        misal     = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_size[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        range_bad = (req_addr >> (ADDR_W + 2)) != '0;
        chk_err   = size_bad ? 2'b10 : misal ? 2'b01 : range_bad ? 2'b10 : 2'b00;
        case (req_size[1:0])
            2'b00:   begin be_d = 4'b0001 << req_addr[1:0]; wdata_d = {4{req_wdata[7:0]}};  end
            2'b01:   begin be_d = 4'b0011 << req_addr[1:0]; wdata_d = {2{req_wdata[15:0]}}; end
            default: begin be_d = 4'b1111;                  wdata_d = req_wdata;            end
        endcase
    end

    // Pick the addressed lane from the memory word and extend it
    always_comb begin
        byte_sel = mem_rdata[8*off_q +: 8];
        half_sel = mem_rdata[16*off_q[1] +: 16];
        case (size_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'b0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'b0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; accepted requests with errors skip the bus entirely
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req_valid) state_nx = (chk_err == 2'b00) ? S_BUS : S_RESP;
            S_BUS:   if (mem_ack || timed_out) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);

    // Latch the request, drive the memory port and capture the completion
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 2'b00;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    we_q   <= req_we;
                    size_q <= req_size;
                    off_q  <= req_addr[1:0];
                    if (chk_err == 2'b00) begin
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_be    <= be_d;
                        mem_addr  <= req_addr[ADDR_W+1:2];
                        mem_wdata <= wdata_d;
                    end else begin
                        resp_err   <= chk_err;
                        resp_rdata <= '0;
                    end
                end
                S_BUS: if (mem_ack) begin
                    mem_req    <= 1'b0;
                    resp_err   <= 2'b00;
                    resp_rdata <= we_q ? '0 : load_data;
                end else if (timed_out) begin
                    mem_req    <= 1'b0;
                    resp_err   <= 2'b11;
                    resp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_lsu.sv
// tb_rv32i_lsu: randomized bench for rv32i_lsu. It compares the design against
// a byte-addressed memory model and arithmetic expectations for each access.
module tb_rv32i_lsu;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned NBYTES = 4 * (1 << ADDR_W);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_size = '0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_err;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack = 1'b0;
    logic [31:0]       mem_rdata = '0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [7:0]  mem_b [NBYTES];

    rv32i_lsu #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, failures so far=%0d required=0", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned size_bytes(input logic [2:0] sz);
        return 1 << sz[1:0];
    endfunction

    function automatic logic [1:0] model_err(input logic we, input logic [2:0] sz, input logic [31:0] a);
        bit legal;
        legal = we ? (sz <= 3'd2) : (sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 2'b10;
        if (a % size_bytes(sz) != 0) return 2'b01;
        if (a >= NBYTES) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int unsigned base;
        base = (a / 4) * 4;
        return {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a);
        longint unsigned v;
        int unsigned     n;
        n = size_bytes(sz);
        v = 0;
        for (int unsigned j = 0; j < n; j++) v += longint'(mem_b[a + j]) << (8 * j);
        if (!sz[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // ---------------- transaction driver ----------------
    task automatic run_req(input logic we, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input int unsigned waits);
        logic [1:0]      e;
        int unsigned     n;
        logic [3:0]      be_exp;
        logic [31:0]     wd_exp;
        logic [31:0]     rd_exp;
        e  = model_err(we, sz, a);
        n  = size_bytes(sz);
        be_exp = 4'(((1 << n) - 1) << (a % 4));
        wd_exp = (n == 4) ? wd : (n == 2) ? (wd & 32'hFFFF) * 32'h0001_0001
                                          : (wd & 32'hFF) * 32'h0101_0101;
        @(negedge clk);
        check("ready_before", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 3'($urandom);
        if (e != 2'b00) begin
            @(negedge clk);
            check("err_resp_valid", resp_valid, 1);
            check("err_code", resp_err, e);
            check("err_rdata", resp_rdata, 0);
            check("err_no_mem_req", mem_req, 0);
        end else begin
            rd_exp = we ? 32'h0 : model_load(sz, a);
            for (int unsigned k = 0; k <= waits; k++) begin
                @(negedge clk);
                check("bus_mem_req", mem_req, 1);
                check("bus_ready", req_ready, 0);
                check("bus_resp_valid", resp_valid, 0);
                check("bus_we", mem_we, we);
                check("bus_be", mem_be, be_exp);
                check("bus_addr", mem_addr, a / 4);
                if (we) check("bus_wdata", mem_wdata, wd_exp);
                mem_rdata = (k == waits) ? model_word(a) : $urandom;
                mem_ack   = (k == waits);
                @(posedge clk);
                #1 mem_ack = 1'b0;
            end
            if (we) for (int unsigned j = 0; j < n; j++) mem_b[a + j] = 8'(wd >> (8 * j));
            @(negedge clk);
            check("resp_valid", resp_valid, 1);
            check("resp_err", resp_err, 0);
            check("resp_rdata", resp_rdata, rd_exp);
            check("resp_mem_req", mem_req, 0);
        end
        @(negedge clk);
        check("resp_pulse_end", resp_valid, 0);
        check("ready_after", req_ready, 1);
    endtask

    initial begin
        for (int unsigned i = 0; i < NBYTES; i++) mem_b[i] = 8'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;

        // Directed cases
        run_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
        run_req(1'b1, 3'b000, 32'h13, 32'h0000_00A5, 0);
        run_req(1'b0, 3'b000, 32'h13, 32'h0, 1);
        check("lb_a5", resp_rdata, 32'hFFFF_FFA5);
        run_req(1'b0, 3'b100, 32'h13, 32'h0, 0);
        check("lbu_a5", resp_rdata, 32'h0000_00A5);
        mem_b[6] = 8'h01; mem_b[7] = 8'h80;
        run_req(1'b0, 3'b001, 32'h06, 32'h0, 3);
        check("lh_8001", resp_rdata, 32'hFFFF_8001);
        run_req(1'b0, 3'b010, 32'h02, 32'h0, 0);
        run_req(1'b0, 3'b011, 32'h00, 32'h0, 0);
        run_req(1'b0, 3'b010, 32'h200, 32'h0, 0);
        run_req(1'b1, 3'b011, 32'h04, 32'h0, 0);
        run_req(1'b0, 3'b001, 32'h201, 32'h0, 0);
        check("prio_misal_over_range", resp_err, 2'b01);

        // Stray mem_ack in IDLE must be ignored
        @(negedge clk); mem_ack = 1'b1;
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_resp_valid", resp_valid, 0);
        check("stray_ack_ready", req_ready, 1);

        // Reset in the second BUS cycle drops the access
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'b010; req_addr = 32'h40; req_wdata = 32'h1234_5678;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); check("rstmid_bus1", mem_req, 1);
        @(negedge clk); check("rstmid_bus2", mem_req, 1); rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_mem_req", mem_req, 0);
        check("rstmid_resp_valid", resp_valid, 0);
        check("rstmid_ready", req_ready, 1);
        @(negedge clk); check("rstmid_no_late_resp", resp_valid, 0);
        run_req(1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, 0);
        run_req(1'b0, 3'b010, 32'h40, 32'h0, 2);

`ifdef LSU_TIMEOUT_EN
        // No ack: 15 BUS cycles, then a timeout response
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h20;
        @(posedge clk); #1 req_valid = 1'b0;
        for (int unsigned k = 0; k < 15; k++) begin
            @(negedge clk); check("to_mem_req_held", mem_req, 1);
        end
        @(negedge clk);
        check("to_resp_valid", resp_valid, 1);
        check("to_err", resp_err, 2'b11);
        check("to_rdata", resp_rdata, 0);
        check("to_mem_req_low", mem_req, 0);
        @(negedge clk);
        // Ack in the 15th BUS cycle completes normally
        run_req(1'b0, 3'b010, 32'h20, 32'h0, 14);
`endif

        // Randomized traffic
        for (int unsigned t = 0; t < 200; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, NBYTES - 1));
            run_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
